// File: rtl/seg_scan_if.sv
// Display-side bus of the 7-segment scan controller: value/dp load handshake,
// live digit controls and the active-low pin drives.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    load_ack;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    lz_suppress;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
    logic                    frame_tick;

    modport master (
        output value_in, dp_in, load, digit_en, lz_suppress,
        input  load_ack, an_n, seg_n, dp_n, frame_tick
    );

    modport slave (
        input  value_in, dp_in, load, digit_en, lz_suppress,
        output load_ack, an_n, seg_n, dp_n, frame_tick
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Hex nibble to 7-segment pattern {g,f,e,d,c,b,a}, active-high.
// Combinational, zero latency.
// No flow control.
module bin_to_seg (
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    always_comb begin
        seg = 7'h00;
        case (nibble)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end
endmodule

// Time-multiplexed common-anode 7-segment scanner with frame-synchronous value loads.
// Pins lag the slot counter by one cycle; a load is acked the cycle after the frame-end commit.
// load is never refused: a newer load overwrites an uncommitted one.
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW  = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

    typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_val;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [4*NUM_DIGITS-1:0] pend_val;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic                    pend_vld;

    logic                    slot_end;
    logic                    frame_end;
    logic [CW-1:0]           cnt_nxt;
    logic [IW-1:0]           idx_nxt;
    logic [3:0]              nibble;
    logic [6:0]              seg_raw;
    logic [NUM_DIGITS-1:0]   supp;
    logic [NUM_DIGITS-1:0]   an_on;
    logic                    zero_run;
    logic                    lit;

    always_comb begin
        slot_end  = (cnt == CNT_LAST);
        frame_end = slot_end && (idx == IDX_LAST);
        cnt_nxt   = slot_end ? '0 : cnt + 1'b1;
        idx_nxt   = idx;
        if (slot_end) begin
            idx_nxt = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        zero_run = bus.lz_suppress;
        supp     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow_val[4*i +: 4] == 4'h0);
            supp[i]  = zero_run && (i != 0);
        end
    end

    always_comb begin
        an_on      = '1;
        an_on[idx] = 1'b0;
    end

    assign nibble = shadow_val[{idx, 2'b00} +: 4];
    assign lit    = bus.digit_en[idx] && !supp[idx];

    bin_to_seg u_dec (
        .nibble (nibble),
        .seg    (seg_raw)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BLANK;
            cnt            <= '0;
            idx            <= '0;
            shadow_val     <= '0;
            shadow_dp      <= '0;
            pend_val       <= '0;
            pend_dp        <= '0;
            pend_vld       <= 1'b0;
            bus.an_n       <= '1;
            bus.seg_n      <= 7'h7F;
            bus.dp_n       <= 1'b1;
            bus.load_ack   <= 1'b0;
            bus.frame_tick <= 1'b0;
        end else begin
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            state <= (cnt_nxt < CNT_SHOW) ? BLANK : SHOW;
            // Look-ahead so the pulse coincides with the commit cycle itself.
            bus.frame_tick <= (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);

            if (state == SHOW && lit) begin
                bus.an_n  <= an_on;
                bus.seg_n <= ~seg_raw;
                bus.dp_n  <= ~shadow_dp[idx];
            end else begin
                bus.an_n  <= '1;
                bus.seg_n <= 7'h7F;
                bus.dp_n  <= 1'b1;
            end

            // Shadow only moves at the frame boundary so a frame is never torn.
            if (frame_end) begin
                if (bus.load) begin
                    shadow_val <= bus.value_in;
                    shadow_dp  <= bus.dp_in;
                end else if (pend_vld) begin
                    shadow_val <= pend_val;
                    shadow_dp  <= pend_dp;
                end
                pend_vld     <= 1'b0;
                bus.load_ack <= bus.load || pend_vld;
            end else begin
                bus.load_ack <= 1'b0;
                if (bus.load) begin
                    pend_val <= bus.value_in;
                    pend_dp  <= bus.dp_in;
                    pend_vld <= 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Time-multiplexed scan controller for a common-anode multi-digit 7-segment display.
- Shares one internal bin_to_seg hex decoder across NUM_DIGITS digits: selects one nibble per slot, inverts the decoder output to active-low, and drives the anodes.
- Provides tear-free frame-synchronous value updates (load/ack), per-digit enables, decimal points, a ghosting blank guard and leading-zero suppression.
- Sits between the processor's display/debug register and the board pins.

Parameters:
NUM_DIGITS, 8, digits scanned; legal 1..8
REFRESH_DIV, 100000, clock cycles per digit slot; must be >= 2
BLANK_CYCLES, 16, cycles at start of each slot with all anodes off; legal 1..REFRESH_DIV-1

Ports:
clk  in  1  system clock; all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
value_in  in  4*NUM_DIGITS  hex value; digit i = value_in[4i+3:4i], digit 0 rightmost
dp_in  in  NUM_DIGITS  decimal point request per digit, active-high
load  in  1  single-cycle request to display value_in/dp_in
load_ack  out  1  one-cycle pulse when a load is committed to the shadow register
digit_en  in  NUM_DIGITS  per-digit enable; 0 blanks that digit
lz_suppress  in  1  1 = blank leading zero digits
an_n  out  NUM_DIGITS  anode drives, active-low, at most one low
seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low
dp_n  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse on the final cycle of each frame

Behaviour:
- Reset (async assert, sync release): an_n all 1, seg_n 7'h7F, dp_n 1, load_ack 0, frame_tick 0; slot counter 0, digit index 0, state BLANK; shadow value, shadow dp and pending registers cleared; pending_valid 0.
- Slot counter runs 0..REFRESH_DIV-1, then wraps. State is BLANK for counts 0..BLANK_CYCLES-1 and SHOW for the rest.
- On counter wrap, digit index increments. Index NUM_DIGITS-1 wraps to 0.
- frame_tick = 1 when counter = REFRESH_DIV-1 and index = NUM_DIGITS-1.
- All outputs are registered. Output values follow the state and index of the previous cycle, so the first anode goes low at cycle BLANK_CYCLES+1 after reset release.
- BLANK: an_n all 1, seg_n 7'h7F, dp_n 1.
- SHOW: the shadow nibble of the current digit drives bin_to_seg, and seg_n is the inverted decoder output.
  - an_n[index] is low if digit_en[index]=1 and the digit is not suppressed.
  - Otherwise an_n stays all 1 for the slot. A disabled digit still consumes its time slot.
  - dp_n = ~shadow_dp[index] while the anode is on, else 1.
- Leading-zero suppression: when lz_suppress=1, digit i is suppressed if the shadow nibbles of i and of every higher digit are 0. Digit 0 is never suppressed. Evaluated on the shadow value.
- Load handshake:
  - load=1 stores value_in/dp_in in the pending register and sets pending_valid.
  - A later load before commit overwrites the pending register; the newest value wins.
- Commit happens on the frame_tick cycle, in the same cycle as the counter/index wrap:
  - If load=1 in that cycle, value_in/dp_in are committed directly (bypass).
  - Else, if pending_valid=1, the pending register is committed and pending_valid clears.
  - load_ack pulses in the cycle after the commit.
- The shadow value never changes mid-frame, so a frame is never torn.
- Mid-operation reset: all state returns to the reset values immediately, and any pending load is discarded with no ack.
- digit_en and lz_suppress are sampled live, not shadowed.

Test Plan:
- NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2, reset release -> an_n=4'hF for cycles 1..2, then an_n=4'hE for cycles 3..8. seg_n=7'b1000000 (digit "0"). an_n=4'hD appears at cycle 11.
- load value_in=16'h00A3, dp_in=4'b0010 mid-frame -> shadow holds until frame_tick. load_ack follows 1 cycle after. Digit 0 seg_n=7'b0110000 ("3"), digit 1 seg_n=7'b0001000 ("A") with dp_n=0.
- Same value with lz_suppress=1 -> digits 2 and 3 keep an_n high during their SHOW windows. With value 16'h0000, only digit 0 lights and shows "0".
- Two loads (16'h1111 then 16'h2222) within one frame -> exactly one load_ack; the display shows 2222. A load on the frame_tick cycle commits that value with no extra frame delay.
- digit_en=4'b1011 -> digit 2 slot is all blank, but the timing of digits 3 and 0 is unchanged. frame_tick period = 32 cycles throughout.
- Assert rst_n low during SHOW with a load pending -> an_n=4'hF and seg_n=7'h7F immediately (async). No load_ack; the shadow value is 0 after release.
